// File: rtl/hilo_unit_pkg.sv
// Shared constants and helpers for the execute-stage HI/LO unit:
// funct codes, divide width and the HI/LO write record.
package hilo_unit_pkg;

  localparam int DIV_ITERS = 32;

  localparam logic [5:0] EXE_MFHI  = 6'b010000;
  localparam logic [5:0] EXE_MTHI  = 6'b010001;
  localparam logic [5:0] EXE_MFLO  = 6'b010010;
  localparam logic [5:0] EXE_MTLO  = 6'b010011;
  localparam logic [5:0] EXE_MULT  = 6'b011000;
  localparam logic [5:0] EXE_MULTU = 6'b011001;
  localparam logic [5:0] EXE_DIV   = 6'b011010;
  localparam logic [5:0] EXE_DIVU  = 6'b011011;

  typedef struct packed {
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_wr_t;

  // Two's-complement negate when neg is set; wraps naturally for 0x80000000.
  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/hilo_unit_if.sv
// E-stage command bus between the pipeline and the HI/LO unit.
interface hilo_unit_if;
  // valid_e qualifies the E-stage command; while stall_e is high the pipeline
  // keeps the same instruction in E, and a dropped valid_e means a bubble.
  logic        valid_e;
  logic        hilowrite;
  logic [5:0]  funct_e;
  logic        rtype_e;
  logic [31:0] srca_e;
  logic [31:0] srcb_e;
  logic        flush_e;
  logic        stall_e;
  logic [31:0] hilo_rdata;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [1:0]  div_state;

  modport master (
    output valid_e, hilowrite, funct_e, rtype_e, srca_e, srcb_e, flush_e,
    input  stall_e, hilo_rdata, hi_o, lo_o, div_state
  );

  modport slave (
    input  valid_e, hilowrite, funct_e, rtype_e, srca_e, srcb_e, flush_e,
    output stall_e, hilo_rdata, hi_o, lo_o, div_state
  );
endinterface

// File: rtl/hilo_unit_div_iter.sv
// Sequential restoring divider: latches magnitudes on start, one quotient bit
// per cycle, presents signed-corrected results alongside the done pulse.
module hilo_unit_div_iter
  import hilo_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic        running;
  logic [4:0]  cnt;
  logic [31:0] rem_q, quo_q, dvs_q;
  logic        neg_q, neg_r, zero_q;

  logic [32:0] rem_sh;
  logic        fits;
  logic [31:0] rem_nx, quo_nx;
  logic        sgn_a, sgn_b;

  assign sgn_a = is_signed & dividend[31];
  assign sgn_b = is_signed & divisor[31];

  // The trial difference always fits in 32 bits when it is kept.
  assign rem_sh = {rem_q, quo_q[31]};
  assign fits   = rem_sh >= {1'b0, dvs_q};
  assign rem_nx = fits ? (rem_sh[31:0] - dvs_q) : rem_sh[31:0];
  assign quo_nx = {quo_q[30:0], fits};

  assign done      = running & ~abort & (cnt == 5'(DIV_ITERS - 1));
  assign quotient  = zero_q ? 32'hFFFF_FFFF : cond_neg(quo_nx, neg_q);
  assign remainder = cond_neg(rem_nx, neg_r);

  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      rem_q   <= '0;
      quo_q   <= cond_neg(dividend, sgn_a);
      dvs_q   <= cond_neg(divisor, sgn_b);
      neg_q   <= sgn_a ^ sgn_b;
      neg_r   <= sgn_a;
      zero_q  <= (divisor == 32'd0);
    end else if (running) begin
      if (abort || done) begin
        running <= 1'b0;
      end
      if (!abort) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        cnt   <= cnt + 5'd1;
      end
    end
  end

endmodule

// File: rtl/hilo_unit.sv
// Execute-stage HI/LO block: HI/LO registers, MFHI/MFLO read mux, MTHI/MTLO,
// single-cycle multiply and a stalling iterative divide.
module hilo_unit
  import hilo_unit_pkg::*;
(
  input logic       clk,
  input logic       rst,
  hilo_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t      state, state_nx;
  logic [31:0] hi_q, lo_q;
  logic        cmd_active, div_start, div_abort, div_done;
  logic        is_div, is_mult, mult_signed;
  logic [31:0] div_quo, div_rem;
  logic [63:0] prod;
  hilo_wr_t    wr;

  assign cmd_active  = bus.valid_e & bus.rtype_e & ~bus.flush_e;
  assign is_div      = (bus.funct_e == EXE_DIV) | (bus.funct_e == EXE_DIVU);
  assign is_mult     = (bus.funct_e == EXE_MULT) | (bus.funct_e == EXE_MULTU);
  assign mult_signed = (bus.funct_e == EXE_MULT);
  assign div_start   = (state == IDLE) & cmd_active & is_div;

  // Sign-extending to 64 bits lets one unsigned multiplier serve both forms.
  assign prod = {{32{mult_signed & bus.srca_e[31]}}, bus.srca_e}
              * {{32{mult_signed & bus.srcb_e[31]}}, bus.srcb_e};

  hilo_unit_div_iter u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .is_signed (bus.funct_e == EXE_DIV),
    .abort     (div_abort),
    .dividend  (bus.srca_e),
    .divisor   (bus.srcb_e),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (div_start) state_nx = RUN;
      RUN:     if (bus.flush_e) state_nx = IDLE;
               else if (div_done) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.stall_e   = div_start | (state == RUN);
    bus.div_state = state;
    div_abort     = (state == RUN) & bus.flush_e;
  end

  // One writer per cycle: divide completion, then multiply, then MTHI/MTLO.
  always_comb begin
    wr = '0;
    if (div_done) begin
      wr = '{hi_we: 1'b1, lo_we: 1'b1, hi: div_rem, lo: div_quo};
    end else if (state == IDLE && cmd_active) begin
      if (is_mult) begin
        wr = '{hi_we: 1'b1, lo_we: 1'b1, hi: prod[63:32], lo: prod[31:0]};
      end else if (bus.hilowrite) begin
        wr.hi    = bus.srca_e;
        wr.lo    = bus.srca_e;
        wr.hi_we = (bus.funct_e == EXE_MTHI);
        wr.lo_we = (bus.funct_e == EXE_MTLO);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (wr.hi_we) hi_q <= wr.hi;
      if (wr.lo_we) lo_q <= wr.lo;
    end
  end

  always_comb begin
    bus.hilo_rdata = '0;
    if (cmd_active && bus.funct_e == EXE_MFHI) bus.hilo_rdata = hi_q;
    if (cmd_active && bus.funct_e == EXE_MFLO) bus.hilo_rdata = lo_q;
    bus.hi_o = hi_q;
    bus.lo_o = lo_q;
  end

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Execute-stage HI/LO block: consumer of the decoder's hilowrite control and funct field.
- Holds the HI and LO architectural registers and serves MFHI/MFLO reads.
- Performs MTHI/MTLO writes, single-cycle MULT/MULTU, and a 32-iteration DIV/DIVU.
- Raises a stall to the hazard unit while a divide runs.

Parameters:
- DIV_ITERS, 32, number of restoring-divide iterations; equals operand width, fixed at 32.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- valid_e  in  1  E-stage instruction valid (not a bubble)
- hilowrite  in  1  decoder control: MTHI/MTLO in E stage
- funct_e  in  6  funct field of the E-stage instruction (R-type only)
- rtype_e  in  1  E-stage op == 000000
- srca_e  in  32  rs value, already forwarded
- srcb_e  in  32  rt value, already forwarded
- flush_e  in  1  E-stage flush; aborts any in-flight divide
- stall_e  out  1  hold IF/ID/E; high while a divide is pending
- hilo_rdata  out  32  MFHI → HI, MFLO → LO, otherwise 0
- hi_o  out  32  current HI register
- lo_o  out  32  current LO register

Behaviour:
- Reset: all of the following are 0 on the first edge with rst=1, regardless of state: HI, LO, stall_e, hilo_rdata, FSM state (IDLE), iteration counter, divide datapath registers.
- Command decode: a command is active when valid_e & rtype_e & !flush_e, with funct codes:
  - MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011
  - MULT 011000, MULTU 011001, DIV 011010, DIVU 011011
- MTHI/MTLO:
  - Write only when hilowrite=1: HI or LO ← srca_e at the edge ending the cycle.
  - funct MTHI/MTLO with hilowrite=0 is ignored.
- MULT/MULTU:
  - Full 64-bit product, signed or unsigned; HI ← [63:32], LO ← [31:0] at the end of the issue cycle.
  - No stall.
- MFHI/MFLO:
  - hilo_rdata is combinational from the HI/LO registers.
  - A write in cycle T is visible to MFHI/MFLO in cycle T+1. No same-cycle bypass is needed, since only one E-stage instruction exists per cycle.
- Divide FSM, states IDLE, RUN, DONE:
  - IDLE, DIV/DIVU active in cycle T: stall_e=1 combinationally. Latch |dividend|, |divisor|, sign flags and the signed/unsigned mode; counter ← 0; go to RUN.
  - RUN, cycles T+1..T+32: one restoring step per cycle (shift remainder:quotient left, trial subtract, set quotient bit); stall_e=1; counter += 1.
  - At the edge ending T+32: apply signs, write HI ← remainder and LO ← quotient, go to DONE.
  - DONE, cycle T+33: stall_e=0. The still-present DIV in E is NOT reissued. Go to IDLE.
  - Total stall is 33 cycles, T..T+32.
- Signed divide:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - 0x80000000 / -1 gives LO=0x80000000, HI=0 (natural two's-complement wrap).
- Divide by zero (DIV and DIVU): full 33-cycle stall, then HI ← srca_e as latched, LO ← 0xFFFFFFFF.
- flush_e in RUN or on the issue cycle: abort, go to IDLE next edge, stall_e=0 the following cycle. HI/LO are unchanged.
- rst mid-divide: identical to reset from IDLE.
- Commands other than the divide are ignored while the FSM is in RUN or DONE. The pipeline is stalled, so none should arrive.
- MULT or MTHI/MTLO in the same cycle as a DONE-state write cannot occur. If it does, the divide result wins.
- HI/LO have exactly one writer per cycle. Priority: divide completion > MULT/MULTU > MTHI/MTLO.

Decomposition:
- Funct constants go in the shared defines header: EXE_MFHI, EXE_MTHI, EXE_MFLO, EXE_MTLO, EXE_MULT, EXE_MULTU, EXE_DIV, EXE_DIVU.
- Divide FSM state encodings are local parameters of this block.
- One sub-module is natural: div_iter, the sequential restoring divider. It has start/signed/abort inputs, a done pulse and 32-bit quotient/remainder outputs.
- hilo_unit keeps the HI/LO registers, the multiplier, command decode and stall generation.

Test Plan:
- Reset, then MTHI srca=0x12345678 (hilowrite=1), next cycle MFHI → hilo_rdata=0x12345678. MFLO → 0.
- MULT 0xFFFFFFFF × 0x00000002 → HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE. stall_e stays 0.
- DIV -7 / 2:
  - stall_e high exactly 33 cycles.
  - Then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
  - stall_e=0 in the DONE cycle, with no second divide started.
- DIVU 100 / 0 → after 33 stall cycles HI=100, LO=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU issued, flush_e pulsed at iteration 10 → stall_e low the next cycle; HI/LO keep their prior values (0xAAAA0000/0x0000BBBB preloaded).
- rst asserted at iteration 20 of a DIV → HI=LO=0, stall_e=0 after the edge. A new DIVU 9/4 then completes normally with LO=2, HI=1.
